div_timer_arbiter: RTL and testbench

Round-robin arbiter and sequencer for one shared divide-by-N counter. Up to NREQ requesters each ask for a timed interval of programmable length. The block grants the counter to one requester at a time, runs it from 0 to that requester's period, and returns a one-cycle completion pulse to the owner. It also drives a divided-clock-style toggle output that flips on every completed interval. It sits between the control logic that needs delays or ticks and the single counter resource, replacing per-requester dividers.

---
 rtl/div_timer_arbiter.sv | 96 +++++++++
 tb/tb_div_timer_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_timer_arbiter.sv
// Round-robin arbiter granting one shared 0..period counter to NREQ requesters,
// with a one-cycle done pulse to the owner and a toggle per completed interval.
module div_timer_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 7
) (
    input  logic              clk,
    input  logic              arst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] period,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [W-1:0]      q,
    output logic [NREQ-1:0]   done,
    output logic              toggle
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] COUNT = 1'b1;

    logic [0:0]   state;
    logic [PW-1:0] ptr;   // last winner; doubles as the current owner while counting
    logic [W-1:0]  maxv;
    logic [PW-1:0] pick;
    logic          pick_valid;
    logic [W-1:0]  slice [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = period[i*W +: W];
    end

    // Scan from farthest to nearest after ptr so the nearest set request wins.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no latch is inferred.
        pick       = ptr;
        pick_valid = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            logic [PW-1:0] idx;
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req[idx]) begin
                pick       = idx;
                pick_valid = 1'b1;
            end
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (arst) begin
            state  <= IDLE;
            grant  <= '0;
            busy   <= 1'b0;
            q      <= '0;
            done   <= '0;
            toggle <= 1'b0;
            maxv   <= '0;
            ptr    <= PW'(NREQ - 1);
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant <= NREQ'(1) << pick;
                        busy  <= 1'b1;
                        q     <= '0;
                        maxv  <= slice[pick];
                        ptr   <= pick;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    // Abort takes precedence over reaching the terminal count.
                    if (!req[ptr]) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        q     <= '0;
                        state <= IDLE;
                    end else if (q == maxv) begin
                        done   <= grant;
                        toggle <= ~toggle;
                        grant  <= '0;
                        busy   <= 1'b0;
                        q      <= '0;
                        state  <= IDLE;
                    end else begin
                        q <= q + W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_timer_arbiter.sv
// Self-checking bench for div_timer_arbiter: per-cycle comparison against a
// transaction-level model plus hand-computed literal checkpoints.
module tb_div_timer_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 7;

    logic              clk = 1'b0;
    logic              arst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] period;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [W-1:0]      q;
    logic [NREQ-1:0]   done;
    logic              toggle;

    int errors = 0;
    int checks = 0;

    div_timer_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk    (clk),
        .arst   (arst),
        .req    (req),
        .period (period),
        .grant  (grant),
        .busy   (busy),
        .q      (q),
        .done   (done),
        .toggle (toggle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an interval is (owner, length, elapsed); outputs are derived from it.
    int m_owner   = -1;
    int m_len     = 0;
    int m_elapsed = 0;
    int m_last    = NREQ - 1;
    int m_flips   = 0;
    int m_done    = -1;

    always @(posedge clk) begin
        m_done = -1;
        if (arst) begin
            m_owner = -1;
            m_elapsed = 0;
            m_last = NREQ - 1;
            m_flips = 0;
        end else if (m_owner < 0) begin
            for (int k = 1; k <= NREQ; k++) begin
                int c;
                c = (m_last + k) % NREQ;
                if (req[c]) begin
                    m_owner = c;
                    m_len = int'(period[c*W +: W]);
                    m_elapsed = 0;
                    m_last = c;
                    break;
                end
            end
        end else if (!req[m_owner]) begin
            m_owner = -1;
        end else if (m_elapsed == m_len) begin
            m_done = m_owner;
            m_flips++;
            m_owner = -1;
        end else begin
            m_elapsed++;
        end
    end

    bit cmp_on = 1'b0;

    always @(negedge clk) begin
        if (cmp_on) begin
            check("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            check("busy",  32'(busy),  32'(m_owner >= 0));
            check("q",     32'(q),     (m_owner >= 0) ? 32'(m_elapsed) : 32'd0);
            check("done",  32'(done),  (m_done >= 0) ? (32'd1 << m_done) : 32'd0);
            check("toggle", 32'(toggle), 32'(m_flips % 2));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_period(input int i, input int p);
        period[i*W +: W] = W'(p);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        tick(2);
        arst = 1'b0;
    endtask

    logic saved_toggle;

    initial begin
        arst = 1'b1;
        req = '0;
        period = '0;
        tick(2);
        cmp_on = 1'b1;
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_q", 32'(q), 32'd0);
        check("rst_toggle", 32'(toggle), 32'd0);
        arst = 1'b0;

        // Single interval, period 3.
        req = 4'b0001;
        set_period(0, 3);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("t1_grant", 32'(grant), 32'h1);
            check("t1_q", 32'(q), 32'(i));
        end
        tick(1);
        req = '0;
        check("t1_done", 32'(done), 32'h1);
        check("t1_toggle", 32'(toggle), 32'd1);
        check("t1_busy", 32'(busy), 32'd0);
        tick(2);

        // All four requesting, period 2 each: round robin from requester 0.
        do_reset();
        for (int i = 0; i < NREQ; i++) set_period(i, 2);
        req = 4'b1111;
        tick(1);
        for (int k = 0; k < 5; k++) begin
            check("t2_grant", 32'(grant), 32'd1 << (k % NREQ));
            check("t2_toggle", 32'(toggle), 32'(k % 2));
            if (k < 4) tick(4);
        end
        req = '0;  // aborts the fifth interval
        tick(3);

        // Period 0 gives a one-cycle grant; the next pick wraps to requester 0.
        req = 4'b0100;
        set_period(2, 0);
        set_period(0, 1);
        tick(1);
        check("t3_grant", 32'(grant), 32'h4);
        check("t3_q", 32'(q), 32'd0);
        req = 4'b0101;
        tick(1);
        check("t3_done", 32'(done), 32'h4);
        req = 4'b0001;
        tick(1);
        check("t3_wrap", 32'(grant), 32'h1);
        tick(2);
        req = '0;
        tick(2);

        // Abort at q=2, then pending requester 1 takes over.
        req = 4'b0001;
        set_period(0, 5);
        set_period(1, 1);
        tick(3);
        check("t4_q", 32'(q), 32'd2);
        saved_toggle = toggle;
        req = 4'b0010;
        tick(1);
        check("t4_abort_grant", 32'(grant), 32'd0);
        check("t4_abort_done", 32'(done), 32'd0);
        check("t4_abort_toggle", 32'(toggle), 32'(saved_toggle));
        tick(1);
        check("t4_next", 32'(grant), 32'h2);
        tick(2);
        check("t4_done", 32'(done), 32'h2);
        req = '0;
        tick(2);

        // Reset mid-count, then requester 0 wins first.
        req = 4'b0001;
        set_period(0, 6);
        tick(5);
        check("t5_q", 32'(q), 32'd4);
        arst = 1'b1;
        tick(1);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_q0", 32'(q), 32'd0);
        check("t5_done", 32'(done), 32'd0);
        arst = 1'b0;
        req = 4'b0101;
        set_period(0, 2);
        set_period(2, 2);
        tick(1);
        check("t5_first", 32'(grant), 32'h1);
        tick(3);
        req = 4'b0100;
        tick(1);
        check("t5_second", 32'(grant), 32'h4);
        tick(3);
        req = '0;
        tick(2);

        // Period change mid-count is ignored; full-range period counts to 127.
        req = 4'b0001;
        set_period(0, 10);
        tick(3);
        set_period(0, 1);
        tick(8);
        check("t6_q10", 32'(q), 32'd10);
        tick(1);
        check("t6_done", 32'(done), 32'h1);
        set_period(0, 127);
        tick(1);
        check("t6_full_start", 32'(q), 32'd0);
        tick(127);
        check("t6_q127", 32'(q), 32'd127);
        tick(1);
        check("t6_full_done", 32'(done), 32'h1);
        req = '0;
        tick(3);

        cmp_on = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
